// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver: hex decode, per-digit
// decimal points, optional leading-zero blanking, frame-synchronous data capture.
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV  = 100000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Data,
    input  logic [7:0]  DPMask,
    input  logic        Enable,
    output logic [6:0]  A2G,
    output logic [7:0]  AN,
    output logic        DP,
    output logic        FrameDone
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler_r;
    logic [2:0]    digit_r;
    logic [31:0]   shadow_data_r;
    logic [7:0]    shadow_dp_r;

    logic          tick_s;
    logic          load_s;
    logic          blank_s;
    logic [3:0]    nibble_s;
    logic [7:0]    an_s;
    logic [6:0]    a2g_s;
    logic          dp_s;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign tick_s = Enable && (prescaler_r == PRESC_LAST);
    assign load_s = Enable && (prescaler_r == {PW{1'b0}}) && (digit_r == 3'd0);

    // Prescaler and digit index; both freeze while the scan is disabled.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            prescaler_r <= {PW{1'b0}};
            digit_r     <= 3'd0;
        end else if (tick_s) begin
            prescaler_r <= {PW{1'b0}};
            digit_r     <= digit_r + 3'd1;
        end else if (Enable) begin
            prescaler_r <= prescaler_r + PW'(1);
            digit_r     <= digit_r;
        end else begin
            prescaler_r <= prescaler_r;
            digit_r     <= digit_r;
        end
    end

    // Shadow capture at frame start only, so a frame never mixes two words.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            shadow_data_r <= 32'd0;
            shadow_dp_r   <= 8'd0;
        end else if (load_s) begin
            shadow_data_r <= Data;
            shadow_dp_r   <= DPMask;
        end else begin
            shadow_data_r <= shadow_data_r;
            shadow_dp_r   <= shadow_dp_r;
        end
    end

    // Decode of the current digit; blanking suppresses the decimal point too.
    always_comb begin
        nibble_s = shadow_data_r[{digit_r, 2'b00} +: 4];
        blank_s  = BLANK_LZ && (digit_r != 3'd0)
                   && ((shadow_data_r >> {digit_r, 2'b00}) == 32'd0);
        an_s     = 8'hFF;
        a2g_s    = 7'h7F;
        dp_s     = 1'b1;
        if (Enable && !blank_s) begin
            an_s  = ~(8'd1 << digit_r);
            a2g_s = hex_to_seg(nibble_s);
            dp_s  = ~shadow_dp_r[digit_r];
        end else begin
            an_s  = 8'hFF;
            a2g_s = 7'h7F;
            dp_s  = 1'b1;
        end
    end

    // Output register stage.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            AN        <= 8'hFF;
            A2G       <= 7'h7F;
            DP        <= 1'b1;
            FrameDone <= 1'b0;
        end else begin
            AN        <= an_s;
            A2G       <= a2g_s;
            DP        <= dp_s;
            FrameDone <= tick_s && (digit_r == 3'd7);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (blanking off/on) share
// stimulus; a frame-position model predicts every registered output cycle.
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    typedef struct packed {
        logic [6:0] a2g;
        logic [7:0] an;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk = 1'b1;
    logic        reset;
    logic [31:0] data;
    logic [7:0]  dpmask;
    logic        enable;

    logic [6:0] a2g0, a2g1;
    logic [7:0] an0, an1;
    logic       dp0, dp1, fd0, fd1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model state: position inside the frame counted in enabled cycles.
    int          pos    = 0;
    logic [31:0] sh_data = 32'd0;
    logic [7:0]  sh_dp   = 8'd0;
    bit          primed  = 1'b0;

    seg7_scan_driver #(.CLK_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .CLK(clk), .Reset(reset), .Data(data), .DPMask(dpmask), .Enable(enable),
        .A2G(a2g0), .AN(an0), .DP(dp0), .FrameDone(fd0));

    seg7_scan_driver #(.CLK_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
        .CLK(clk), .Reset(reset), .Data(data), .DPMask(dpmask), .Enable(enable),
        .A2G(a2g1), .AN(an1), .DP(dp1), .FrameDone(fd1));

    always #5 clk = ~clk;

    function automatic exp_t model_out(input int p, input logic [31:0] sd,
                                       input logic [7:0] sdp, input logic rst,
                                       input logic en, input bit blz);
        exp_t       e;
        int         d;
        logic [31:0] upper;
        logic [3:0] nib;
        d     = p / DIV;
        upper = sd >> (4 * d);
        nib   = upper[3:0];
        e     = '{a2g: 7'h7F, an: 8'hFF, dp: 1'b1, fd: 1'b0};
        if (!rst && en) begin
            if (!(blz && d > 0 && upper == 32'd0)) begin
                e.an  = ~(8'd1 << d);
                e.a2g = hex_tab[nib];
                e.dp  = ~sdp[d];
            end
            e.fd = (p == FRAME - 1);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference model: predicts the outputs that follow the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) primed = 1'b1;
            if (primed) begin
                q0.push_back(model_out(pos, sh_data, sh_dp, reset, enable, 1'b0));
                q1.push_back(model_out(pos, sh_data, sh_dp, reset, enable, 1'b1));
                if (reset) begin
                    pos     = 0;
                    sh_data = 32'd0;
                    sh_dp   = 8'd0;
                end else if (enable) begin
                    if (pos == 0) begin
                        sh_data = data;
                        sh_dp   = dpmask;
                    end
                    pos = (pos + 1) % FRAME;
                end
            end
        end
    end

    // Monitor: outputs are valid every cycle; compare against queued predictions.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0 && q1.size() > 0) begin
                e = q0.pop_front();
                chk("an_lz0",  an0,             e.an);
                chk("a2g_lz0", {1'b0, a2g0},    {1'b0, e.a2g});
                chk("dp_lz0",  {7'd0, dp0},     {7'd0, e.dp});
                chk("fd_lz0",  {7'd0, fd0},     {7'd0, e.fd});
                e = q1.pop_front();
                chk("an_lz1",  an1,             e.an);
                chk("a2g_lz1", {1'b0, a2g1},    {1'b0, e.a2g});
                chk("dp_lz1",  {7'd0, dp1},     {7'd0, e.dp});
                chk("fd_lz1",  {7'd0, fd1},     {7'd0, e.fd});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_an(input logic [7:0] target, input string nm);
        int i;
        for (i = 0; i < 4 * FRAME && an0 !== target; i++) step(1);
        chk(nm, an0, target);
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset  = 1'b1;
        data   = 32'h12345678;
        dpmask = 8'h00;
        enable = 1'b1;
        step(3);
        reset = 1'b0;
        step(100);

        wait_an(8'hF7, "wait_an_f7");
        data = 32'hFFFFFFFF;
        step(2 * FRAME);

        data = 32'h000000A0;
        step(2 * FRAME + 4);
        data = 32'h00000000;
        dpmask = 8'h04;
        step(2 * FRAME);

        data   = 32'h87654321;
        dpmask = 8'h5A;
        wait_an(8'hDF, "wait_an_df");
        step(1);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(FRAME);

        step(13);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(FRAME + 8);

        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) data = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 31) == 0) dpmask = 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 99) == 0);
            step(1);
        end
        reset  = 1'b0;
        enable = 1'b1;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
